// File: rtl/hl2_hdecimate.sv
`default_nettype none
// ============================================================================
// Module      : hl2_hdecimate
// Description : Horizontal [1 2 1]/4 low-pass filter with 2:1 decimation on a
//               raster-order 16-bit pixel token stream (actor-style ports).
//               Left edge of every row replicates p[0] as p[-1].
// Revision    : 1.0 - initial release
// ============================================================================
module hl2_hdecimate #(
    parameter int IMG_WIDTH = 512,
    parameter int COL_BITS  = 9
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] In1_DATA,
    input  logic        In1_SEND,
    input  logic [15:0] In1_COUNT,
    output logic        In1_ACK,
    output logic [15:0] Out1_DATA,
    output logic        Out1_SEND,
    input  logic        Out1_RDY,
    input  logic        Out1_ACK,
    output logic [15:0] Out1_COUNT
);

    // Phase of the next incoming token within its even/odd pixel pair.
    localparam logic [0:0]          c_ST_EVEN  = 1'b0;
    localparam logic [0:0]          c_ST_ODD   = 1'b1;
    localparam logic [COL_BITS-1:0] c_COL_LAST = COL_BITS'(IMG_WIDTH - 1);
    localparam logic [COL_BITS-1:0] c_COL_ONE  = COL_BITS'(1);

    logic [0:0]          r_state;
    logic [COL_BITS-1:0] r_col;
    logic [15:0]         r_prev_odd;
    logic [15:0]         r_cur_even;
    logic                r_pend;
    logic [15:0]         r_out;

    logic [0:0]          w_state_nxt;
    logic [COL_BITS-1:0] w_col_nxt;
    logic [15:0]         w_prev_odd_nxt;
    logic [15:0]         w_cur_even_nxt;
    logic                w_pend_nxt;
    logic [15:0]         w_out_nxt;

    logic                w_send;
    logic                w_ack;
    logic [15:0]         w_filt;
    logic [1:0]          w_unused_frac;
    logic                w_unused_inputs;

    // COUNT and downstream ACK carry no information for this actor.
    assign w_unused_inputs = ^{In1_COUNT, Out1_ACK};

    // A held result can leave in the same cycle a new odd token is accepted,
    // so input is blocked only while a result is stuck behind Out1_RDY=0.
    assign w_send = r_pend & Out1_RDY;
    assign w_ack  = In1_SEND & (~r_pend | w_send) & ~RESET;

    // 18-bit sum with rounding; the max (4*0xFFFF+2) fits, so bits [17:2] never wrap.
    assign {w_filt, w_unused_frac} = {2'b00, r_prev_odd}
                                   + {1'b0, r_cur_even, 1'b0}
                                   + {2'b00, In1_DATA}
                                   + 18'd2;

    assign In1_ACK    = w_ack;
    assign Out1_SEND  = w_send;
    assign Out1_DATA  = r_out;
    assign Out1_COUNT = 16'h0001;

    // Next-state logic: one consumed token advances the even/odd pair FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_col_nxt      = r_col;
        w_prev_odd_nxt = r_prev_odd;
        w_cur_even_nxt = r_cur_even;
        w_pend_nxt     = r_pend;
        w_out_nxt      = r_out;

        if (w_send) begin
            w_pend_nxt = 1'b0;
        end

        if (w_ack) begin
            if (r_state == c_ST_EVEN) begin
                w_cur_even_nxt = In1_DATA;
                // Column 0 supplies its own left neighbour.
                if (r_col == '0) begin
                    w_prev_odd_nxt = In1_DATA;
                end
                w_col_nxt   = r_col + c_COL_ONE;
                w_state_nxt = c_ST_ODD;
            end else begin
                w_out_nxt      = w_filt;
                w_pend_nxt     = 1'b1;
                w_prev_odd_nxt = In1_DATA;
                w_col_nxt      = (r_col == c_COL_LAST) ? '0 : (r_col + c_COL_ONE);
                w_state_nxt    = c_ST_EVEN;
            end
        end
    end

    // State register; reset discards any partial row and pending result.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= c_ST_EVEN;
            r_col      <= '0;
            r_prev_odd <= '0;
            r_cur_even <= '0;
            r_pend     <= 1'b0;
            r_out      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_prev_odd <= w_prev_odd_nxt;
            r_cur_even <= w_cur_even_nxt;
            r_pend     <= w_pend_nxt;
            r_out      <= w_out_nxt;
        end
    end

endmodule
`default_nettype wire
